// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - pushbutton debounce/press-event and slide-switch tile decode
// Four independent debounce FSMs plus a one-hot switch decoder feeding quit/begin/select pulses.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic       quit_pulse,
    output logic       begin_pulse,
    output logic       sel1_pulse,
    output logic       sel2_pulse,
    output logic       sel_err,
    output logic [3:0] key_level,
    output logic [3:0] tile_idx,
    output logic       tile_valid
);

    localparam int CW = 20;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    logic [3:0] key_s1, key_s2;
    logic [9:0] sw_s1, sw_s2;
    logic [3:0] ev;

    // Keys idle high (released) and switches idle low while in reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_key
            state_t        state;
            logic [CW-1:0] cnt;
            logic          pressed;

            assign pressed = ~key_s2[i];

            always_ff @(posedge CLOCK_50 or negedge resetn) begin
                if (!resetn) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (pressed) begin
                                state <= PRESS_WAIT;
                                cnt   <= '0;
                            end
                        end
                        PRESS_WAIT: begin
                            if (!pressed) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else if (cnt == LAST) begin
                                state <= PRESSED;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        PRESSED: begin
                            if (!pressed) begin
                                state <= RELEASE_WAIT;
                                cnt   <= '0;
                            end
                        end
                        RELEASE_WAIT: begin
                            if (pressed) begin
                                state <= PRESSED;
                                cnt   <= '0;
                            end else if (cnt == LAST) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        default: begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    endcase
                end
            end

            // Only the debounced entry into PRESSED is an event; bounce recovery from RELEASE_WAIT is not.
            assign ev[i]        = (state == PRESS_WAIT) && pressed && (cnt == LAST);
            assign key_level[i] = (state == PRESSED) || (state == RELEASE_WAIT);
        end
    endgenerate

    logic [3:0] ones;
    logic [3:0] idx;

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int j = 0; j < 10; j++) begin
            if (sw_s2[j]) begin
                ones = ones + 4'd1;
                idx  = 4'(j);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tile_idx   <= '0;
            tile_valid <= 1'b0;
        end else begin
            tile_valid <= (ones == 4'd1);
            tile_idx   <= (ones == 4'd1) ? idx : 4'd0;
        end
    end

    // Quit wins outright: any other event in the same cycle is dropped.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            quit_pulse  <= 1'b0;
            begin_pulse <= 1'b0;
            sel1_pulse  <= 1'b0;
            sel2_pulse  <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            quit_pulse  <= ev[0];
            begin_pulse <= ev[1] & ~ev[0];
            sel1_pulse  <= ev[2] & tile_valid & ~ev[0];
            sel2_pulse  <= ev[3] & tile_valid & ~ev[0];
            sel_err     <= (ev[2] | ev[3]) & ~tile_valid & ~ev[0];
        end
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the stable-press/release time in clock cycles (20 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port KEY  input  4  raw pushbuttons, active-low, asynchronous to CLOCK_50; KEY[0]=quit, KEY[1]=begin, KEY[2]=select1, KEY[3]=select2.
REQ-005 SHALL have port SW  input  10  raw slide switches, asynchronous to CLOCK_50.
REQ-006 SHALL have port quit_pulse  output  1  one-cycle pulse on debounced KEY[0] press.
REQ-007 SHALL have port begin_pulse  output  1  one-cycle pulse on debounced KEY[1] press.
REQ-008 SHALL have port sel1_pulse, sel2_pulse  output  1 each  one-cycle pulses on debounced KEY[2]/KEY[3] press with a valid tile.
REQ-009 SHALL have port sel_err  output  1  one-cycle pulse when a select press occurs with no valid tile.
REQ-010 SHALL have port key_level  output  4  debounced pressed level per key, 1=pressed.
REQ-011 SHALL have port tile_idx  output  4  index 0..9 of the single SW bit that is set.
REQ-012 SHALL have port tile_valid  output  1  high when exactly one SW bit is set.

Function
REQ-013 Each KEY bit and SW bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Each key SHALL have an independent 4-state FSM (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) with its own counter, 20 bits minimum.
REQ-015 IDLE -> PRESS_WAIT, counter=0, when the synced key reads pressed.
REQ-016 In PRESS_WAIT: synced released -> IDLE. Pressed and counter==DEBOUNCE_CYCLES-1 -> PRESSED. Otherwise counter+1.
REQ-017 PRESSED -> RELEASE_WAIT, counter=0, when the synced key reads released.
REQ-018 In RELEASE_WAIT: synced pressed -> PRESSED with no new pulse. Released and counter==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise counter+1.
REQ-019 key_level[i] SHALL be 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
REQ-020 Press event SHALL fire only on the PRESS_WAIT->PRESSED transition. The registered pulse is high for exactly the first cycle in PRESSED. Holding a key SHALL never produce a repeat pulse.
REQ-021 Latency SHALL be DEBOUNCE_CYCLES+3 cycles from the first clock edge sampling raw KEY low to the pulse going high (2 sync + 1 FSM entry + DEBOUNCE_CYCLES).
REQ-022 tile_idx/tile_valid SHALL be registered from synced SW, 1 cycle after synchronizer output.
REQ-023 Zero or ≥2 SW bits set SHALL give tile_valid=0 and tile_idx=0.
REQ-024 A select press event SHALL sample tile_valid in the same cycle:
- valid -> sel1_pulse/sel2_pulse.
- invalid -> sel_err only; no select pulse.
REQ-025 Quit priority: a quit event in a cycle SHALL suppress begin/sel1/sel2/sel_err pulses from events in that same cycle. Suppressed events are dropped, not deferred.
REQ-026 Simultaneous select1 and select2 events, no quit, both valid, SHALL give both sel1_pulse and sel2_pulse in that cycle. If invalid, a single sel_err pulse.
REQ-027 A counter SHALL never wrap; it is cleared on every state entry.

Reset
REQ-028 resetn low SHALL asynchronously force all FSMs to IDLE and all counters to 0.
REQ-029 resetn low SHALL reset KEY synchronizer flops to 1 (released) and SW synchronizer flops to 0.
REQ-030 resetn low SHALL drive all outputs to 0, including tile_idx=0 and tile_valid=0.
REQ-031 Reset asserted mid-debounce SHALL discard the pending event; no pulse after release of reset unless a fresh full debounce completes.
REQ-032 A key held through reset deassertion SHALL be debounced as a new press: one pulse, DEBOUNCE_CYCLES+3 cycles after reset release.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 KEY[1] low steady from cycle 0 -> begin_pulse high on cycle 7 only; key_level[1]=1 from cycle 7.
REQ-034 KEY[2] bouncing low 2 cycles, high 1, low steady, with SW=10'b0000100000 -> exactly one sel1_pulse, tile_idx=5, tile_valid=1.
REQ-035 SW=10'b0000000011, KEY[3] pressed -> sel_err one cycle, sel2_pulse never; tile_valid=0, tile_idx=0.
REQ-036 KEY[0] and KEY[1] low on the same edge -> quit_pulse once, begin_pulse never.
REQ-037 KEY[2] held 100 cycles, then released 3 cycles, then pressed again -> one sel1_pulse total; key_level[2] stays 1 throughout.
REQ-038 resetn pulsed low at cycle 5 of a KEY[1] press, key still held -> outputs 0 during reset; one begin_pulse 7 cycles after resetn rises.
